// File: rtl/bnn_vote_accumulator_pkg.sv
// Shared types and helpers for the BNN vote accumulator slice.
package bnn_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int CLASS_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2
    } state_e;

    // Increment val by one when inc is set, never exceeding max_val.
    // Operates on 32-bit containers so callers of any counter width can share it.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val,
                                            input logic        inc);
        if (inc && (val < max_val)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/bnn_vote_accumulator_if.sv
// Control, sample and result bundle between the BNN core side and the vote accumulator.
interface bnn_vote_if
    import bnn_pkg::*;
#(
    parameter int COUNT_W = 8
);
    logic                   ena;
    logic                   start;
    logic                   abort;
    logic [COUNT_W-1:0]     window_len;
    logic                   sample_valid;
    logic [NUM_CLASSES-1:0] class_bits;
    logic                   busy;
    logic                   result_valid;
    logic [CLASS_IDX_W-1:0] result_class;
    logic [COUNT_W-1:0]     result_count;
    logic                   result_none;

    // Driver side: issues control and samples, observes results.
    modport master (
        output ena, start, abort, window_len, sample_valid, class_bits,
        input  busy, result_valid, result_class, result_count, result_none
    );

    // Accumulator side.
    modport slave (
        input  ena, start, abort, window_len, sample_valid, class_bits,
        output busy, result_valid, result_class, result_count, result_none
    );
endinterface

// File: rtl/bnn_vote_accumulator_argmax4.sv
// Combinational 4-way argmax: lowest index wins on ties, flags an all-zero input set.
module bnn_argmax4
    import bnn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [NUM_CLASSES-1:0][W-1:0] cnt_i,
    output logic [CLASS_IDX_W-1:0]        idx_o,
    output logic [W-1:0]                  max_o,
    output logic                          zero_o
);

    logic         lo_sel;
    logic         hi_sel;
    logic         top_sel;
    logic [W-1:0] lo_max;
    logic [W-1:0] hi_max;

    // Two-level tree; strict greater-than keeps the lower index on equality.
    always_comb begin
        lo_sel  = cnt_i[1] > cnt_i[0];
        lo_max  = lo_sel ? cnt_i[1] : cnt_i[0];
        hi_sel  = cnt_i[3] > cnt_i[2];
        hi_max  = hi_sel ? cnt_i[3] : cnt_i[2];
        top_sel = hi_max > lo_max;
        idx_o   = top_sel ? {1'b1, hi_sel} : {1'b0, lo_sel};
        max_o   = top_sel ? hi_max : lo_max;
        zero_o  = (max_o == '0);
    end

endmodule

// File: rtl/bnn_vote_accumulator.sv
// Per-class vote accumulator over a programmable window of BNN inferences.
// Emits the winning class, its vote count and a one-cycle result pulse per window.
module bnn_vote_accumulator
    import bnn_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    bnn_vote_if.slave  bus
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_e                              state_q, state_d;
    logic [NUM_CLASSES-1:0][COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0]                  samp_q, samp_d;
    logic [COUNT_W-1:0]                  len_q, len_d;
    logic                                res_valid_q, res_valid_d;
    logic [CLASS_IDX_W-1:0]              res_class_q, res_class_d;
    logic [COUNT_W-1:0]                  res_count_q, res_count_d;
    logic                                res_none_q, res_none_d;

    logic [CLASS_IDX_W-1:0]              am_idx;
    logic [COUNT_W-1:0]                  am_max;
    logic                                am_zero;
    logic [COUNT_W-1:0]                  samp_inc;

    bnn_argmax4 #(.W(COUNT_W)) u_argmax (
        .cnt_i  (cnt_q),
        .idx_o  (am_idx),
        .max_o  (am_max),
        .zero_o (am_zero)
    );

    assign samp_inc = samp_q + COUNT_W'(1);

    // Next-state logic: window control, vote accumulation and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        samp_d      = samp_q;
        len_d       = len_q;
        res_valid_d = 1'b0;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
        res_none_d  = res_none_q;

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.window_len != '0)) begin
                    cnt_d   = '0;
                    samp_d  = '0;
                    len_d   = bus.window_len;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.sample_valid) begin
                    for (int i = 0; i < NUM_CLASSES; i++) begin
                        cnt_d[i] = COUNT_W'(sat_inc(32'(cnt_q[i]), 32'(CNT_MAX),
                                                    bus.class_bits[i]));
                    end
                    samp_d = samp_inc;
                    if (samp_inc == len_q) begin
                        state_d = ARGMAX;
                    end
                end
            end
            ARGMAX: begin
                state_d = IDLE;
                if (!bus.abort) begin
                    // argmax already yields index 0 / value 0 when every count is zero
                    res_valid_d = 1'b1;
                    res_class_d = am_idx;
                    res_count_d = am_max;
                    res_none_d  = am_zero;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; ena low freezes everything, including the result pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            samp_q      <= '0;
            len_q       <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_count_q <= '0;
            res_none_q  <= 1'b0;
        end else if (bus.ena) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            len_q       <= len_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
            res_none_q  <= res_none_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = res_valid_q;
    assign bus.result_class = res_class_q;
    assign bus.result_count = res_count_q;
    assign bus.result_none  = res_none_q;

endmodule
